// File: rtl/k11_pipe_pkg.sv
// Shared pipeline definitions for k11 stages.
// State codes double as the occupancy count reported by each stage.
package k11_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_BUSY  = ST_BUSY,
    S_FULL  = ST_FULL
  } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Holds at all-ones; only reset clears it.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc_i && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/skid_stage.sv
// Fully-registered valid/ready stage with a 2-entry skid buffer.
// valid, ready and data to both sides come straight from flops.
module skid_stage
  import k11_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_ro,
  output logic [DATA_W-1:0] data_ro,
  input  logic              ready_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  skid_state_e       r_state;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_skid;

  logic w_in;
  logic w_out;
  logic w_stall;

  assign w_in    = valid_i & r_ready;
  assign w_out   = r_valid & ready_i;
  assign w_stall = r_valid & ~ready_i;

  // Flush wins over everything; data regs keep stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_data  <= '0;
      r_skid  <= '0;
    end else if (flush_i) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_in) begin
            r_data  <= data_i;
            r_state <= S_BUSY;
            r_valid <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        S_BUSY: begin
          if (w_in && !w_out) begin
            r_skid  <= data_i;
            r_state <= S_FULL;
            r_ready <= 1'b0;
          end else if (!w_in && w_out) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
          end else if (w_in && w_out) begin
            r_data  <= data_i;
          end
        end
        S_FULL: begin
          if (w_out) begin
            r_data  <= r_skid;
            r_state <= S_BUSY;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (w_stall),
    .count_o (stall_cnt_o)
  );

  assign ready_o  = r_ready;
  assign valid_ro = r_valid;
  assign data_ro  = r_data;
  assign occ_o    = r_state;

endmodule
